// File: rtl/spi_ram_slave_param.sv
// spi_ram_slave_param: SPI-framed slave in front of a parameterised single-port RAM.
// Latency: the command executes in the one MEM cycle after the last frame bit; read data starts on MISO on the edge ending MEM.
// Backpressure: none. The master paces every bit, and SS_n high in any state aborts the frame.
//
// Ports:
//   clk    - single clock; all logic on the rising edge
//   rst_n  - asynchronous active-low reset (RAM contents are not cleared)
//   SS_n   - active-low slave select, sampled on clk
//   MOSI   - serial frame in, MSB first: 2-bit command, then address or data payload
//   MISO   - registered serial read data out, MSB first; 0 outside TX
//
// Commands: 00 set wr_ptr, 01 write RAM[wr_ptr], 10 set rd_ptr, 11 read RAM[rd_ptr].
// Optional feature: define SPI_RAM_AUTO_INC_EN to post-increment wr_ptr after 01
// and rd_ptr after 11, wrapping from MEM_DEPTH-1 to 0.
module spi_ram_slave_param #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  // The payload shift register is sized for the longer of the two payload kinds.
  localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(PW + 3);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  // Index of the final frame bit (2 command bits + N payload bits, counted from 0).
  localparam logic [CW-1:0] LAST_A  = CW'(ADDR_WIDTH + 1);
  localparam logic [CW-1:0] LAST_D  = CW'(DATA_WIDTH + 1);
  localparam logic [CW-1:0] TX_LAST = CW'(DATA_WIDTH - 1);
  // One extra bit so that MEM_DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RX   = 3'd1,
    MEM  = 3'd2,
    TX   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           bit_cnt, bit_cnt_nxt;
  logic [1:0]              cmd, cmd_nxt;
  logic [PW-1:0]           shreg, shreg_nxt;
  logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt;
  logic [ADDR_WIDTH-1:0]   rd_ptr, rd_ptr_nxt;
  logic [DATA_WIDTH-1:0]   tx_reg, tx_reg_nxt;
  logic [DATA_WIDTH-1:0]   tx_shift;
  logic                    miso_nxt;
  logic                    mem_we;
  logic                    wr_in_range;
  logic                    rd_in_range;
  logic                    frame_last;
  logic [DATA_WIDTH-1:0]   rd_data;

  // Not reset: the contents survive rst_n.
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(MEM_DEPTH - 1);

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction
`endif

  assign wr_in_range = ({1'b0, wr_ptr} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, rd_ptr} < DEPTH_LIM);
  assign rd_data     = rd_in_range ? mem[rd_ptr[IW-1:0]] : '0;

  // cmd[0] selects the payload length: 0 -> address, 1 -> data. The end index is
  // always >= 2, so it cannot match while cmd[0] is still stale (bit_cnt == 1).
  assign frame_last  = (bit_cnt == (cmd[0] ? LAST_D : LAST_A));

  // tx_reg shifts left through TX; the next MISO bit is the MSB after the shift.
  assign tx_shift    = tx_reg << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      cmd     <= '0;
      shreg   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tx_reg  <= '0;
      MISO    <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      cmd     <= cmd_nxt;
      shreg   <= shreg_nxt;
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      tx_reg  <= tx_reg_nxt;
      MISO    <= miso_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr[IW-1:0]] <= shreg[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    cmd_nxt     = cmd;
    shreg_nxt   = shreg;
    wr_ptr_nxt  = wr_ptr;
    rd_ptr_nxt  = rd_ptr;
    tx_reg_nxt  = tx_reg;
    miso_nxt    = 1'b0;
    mem_we      = 1'b0;

    if (SS_n) begin
      // A deselect wins over everything, including a pending MEM action.
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_nxt[1]  = MOSI;
          bit_cnt_nxt = CW'(1);
          state_nxt   = RX;
        end

        RX: begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == CW'(1)) begin
            cmd_nxt[0] = MOSI;
          end else begin
            shreg_nxt    = shreg << 1;
            shreg_nxt[0] = MOSI;
            if (frame_last) begin
              state_nxt = MEM;
            end
          end
        end

        MEM: begin
          bit_cnt_nxt = '0;
          state_nxt   = DONE;
          case (cmd)
            2'b00: wr_ptr_nxt = shreg[ADDR_WIDTH-1:0];
            2'b01: begin
              mem_we = wr_in_range;
`ifdef SPI_RAM_AUTO_INC_EN
              wr_ptr_nxt = ptr_inc(wr_ptr);
`endif
            end
            2'b10: rd_ptr_nxt = shreg[ADDR_WIDTH-1:0];
            default: begin
              // The read word and its MSB are registered on the same edge.
              tx_reg_nxt = rd_data;
              miso_nxt   = rd_data[DATA_WIDTH-1];
              state_nxt  = TX;
`ifdef SPI_RAM_AUTO_INC_EN
              rd_ptr_nxt = ptr_inc(rd_ptr);
`endif
            end
          endcase
        end

        TX: begin
          if (bit_cnt == TX_LAST) begin
            state_nxt = DONE;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            tx_reg_nxt  = tx_shift;
            miso_nxt    = tx_shift[DATA_WIDTH-1];
          end
        end

        DONE: state_nxt = DONE;

        default: begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_slave_param.sv
// Directed bench for spi_ram_slave_param: three instances (8/8/256, 8/8/200 and 10/16/1024).
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
// The RAM is observed only through read frames on MISO.
module tb_spi_ram_slave_param;

  logic       clk;
  logic       rst_n;
  logic [2:0] ss_n;
  logic [2:0] mosi;
  logic [2:0] miso;

  int tests;
  int failed;

  spi_ram_slave_param dut0 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
  );

  spi_ram_slave_param #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200)) dut1 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
  );

  spi_ram_slave_param #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .MEM_DEPTH(1024)) dut2 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[2]), .MOSI(mosi[2]), .MISO(miso[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the low n bits of vec MSB first, one per clock, with SS_n low.
  task automatic send_bits(input int inst, input logic [31:0] vec, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      ss_n[inst] = 1'b0;
      mosi[inst] = vec[i];
    end
  endtask

  // Complete non-read frame: bits, the MEM cycle, then one SS_n-high cycle.
  task automatic wr_frame(input int inst, input logic [1:0] cmd,
                          input logic [31:0] payload, input int n);
    logic [31:0] vec;
    vec = ({30'd0, cmd} << n) | payload;
    send_bits(inst, vec, 2 + n);
    @(negedge clk);
    mosi[inst] = 1'b0;
    chk("miso_idle_in_mem", 32'(miso[inst]), 32'd0);
    @(negedge clk);
    ss_n[inst] = 1'b1;
  endtask

  // Read frame (command 11, payload all ones since it is ignored); collects dw MISO bits.
  task automatic rd_frame(input int inst, input int n, input int dw, output logic [31:0] rx);
    logic [31:0] vec;
    vec = (32'd3 << n) | ((32'd1 << n) - 32'd1);
    send_bits(inst, vec, 2 + n);
    @(negedge clk);
    chk("miso_before_tx", 32'(miso[inst]), 32'd0);
    rx = '0;
    for (int k = 0; k < dw; k++) begin
      @(negedge clk);
      rx[dw - 1 - k] = miso[inst];
      mosi[inst] = ~mosi[inst];
    end
    @(negedge clk);
    chk("miso_after_tx", 32'(miso[inst]), 32'd0);
    ss_n[inst] = 1'b1;
  endtask

  task automatic rd_at(input int inst, input logic [31:0] addr, input int aw, input int dw,
                       input logic [31:0] exp, input string tag);
    logic [31:0] rx;
    wr_frame(inst, 2'b10, addr, aw);
    rd_frame(inst, dw, dw, rx);
    chk(tag, rx, exp);
  endtask

  task automatic wr_at(input int inst, input logic [31:0] addr, input logic [31:0] data,
                       input int aw, input int dw);
    wr_frame(inst, 2'b00, addr, aw);
    wr_frame(inst, 2'b01, data, dw);
  endtask

  initial begin
    logic [31:0] rx;
    tests  = 0;
    failed = 0;
    rst_n  = 1'b1;
    ss_n   = 3'b111;
    mosi   = 3'b000;

    // Reset state, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_miso0", 32'(miso[0]), 32'd0);
    chk("rst_miso1", 32'(miso[1]), 32'd0);
    chk("rst_miso2", 32'(miso[2]), 32'd0);
    chk("rst_wr_ptr", 32'(dut0.wr_ptr), 32'd0);
    chk("rst_rd_ptr", 32'(dut0.rd_ptr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reference sequence: RAM[0x0F] = 0x0E, then read it back serially.
    wr_frame(0, 2'b00, 32'h0F, 8);
    wr_frame(0, 2'b01, 32'h0E, 8);
    wr_frame(0, 2'b10, 32'h0F, 8);
    rd_frame(0, 8, 8, rx);
    chk("read_0x0f", rx, 32'h0E);

    // A second address/data pattern with alternating bits.
    wr_at(0, 32'h10, 32'hA5, 8, 8);
    rd_at(0, 32'h10, 8, 8, 32'hA5, "read_0x10");
    rd_at(0, 32'h0F, 8, 8, 32'h0E, "reread_0x0f");

    // A write-data frame deselected after 5 payload bits must leave the RAM unchanged.
    wr_at(0, 32'h20, 32'h11, 8, 8);
    send_bits(0, 32'b01_10110, 7);
    @(negedge clk);
    ss_n[0] = 1'b1;
    @(negedge clk);
    chk("abort_miso", 32'(miso[0]), 32'd0);
    rd_at(0, 32'h20, 8, 8, 32'h11, "abort_ram_kept");

    // Write pointer at the top of memory, followed by two consecutive data writes.
    wr_at(0, 32'h00, 32'h3C, 8, 8);
    wr_frame(0, 2'b00, 32'hFF, 8);
    wr_frame(0, 2'b01, 32'hA5, 8);
    wr_frame(0, 2'b01, 32'h5A, 8);
`ifdef SPI_RAM_AUTO_INC_EN
    rd_at(0, 32'hFF, 8, 8, 32'hA5, "autoinc_ram_ff");
    rd_at(0, 32'h00, 8, 8, 32'h5A, "autoinc_ram_00");
`else
    rd_at(0, 32'hFF, 8, 8, 32'h5A, "noinc_ram_ff");
    rd_at(0, 32'h00, 8, 8, 32'h3C, "noinc_ram_00");
`endif

    // Reset pulsed mid-TX while MISO is 1 (bit 3 of 0x0E).
    wr_frame(0, 2'b10, 32'h0F, 8);
    send_bits(0, 32'h3FF, 10);
    @(negedge clk);
    rx = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rx[4 - k] = miso[0];
    end
    chk("tx_bits_before_rst", rx, 32'b00001);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_miso", 32'(miso[0]), 32'd0);
    chk("rst_mid_tx_wr_ptr", 32'(dut0.wr_ptr), 32'd0);
    chk("rst_mid_tx_rd_ptr", 32'(dut0.rd_ptr), 32'd0);
    ss_n = 3'b111;
    #1 rst_n = 1'b1;

    // Both pointers restart at 0: write and read without setting them.
    wr_frame(0, 2'b01, 32'h99, 8);
    rd_frame(0, 8, 8, rx);
    chk("post_rst_ptr0_word", rx, 32'h99);
    rd_at(0, 32'h0F, 8, 8, 32'h0E, "post_rst_ram_0f");
    rd_at(0, 32'h10, 8, 8, 32'hA5, "post_rst_ram_10");

    // MEM_DEPTH = 200: address 0xC8 is out of range for both write and read.
    wr_at(1, 32'h00, 32'h55, 8, 8);
    wr_at(1, 32'hC7, 32'h44, 8, 8);
    wr_at(1, 32'hC8, 32'h33, 8, 8);
    rd_at(1, 32'hC8, 8, 8, 32'h00, "oor_read_c8");
    rd_at(1, 32'hC7, 8, 8, 32'h44, "last_word_c7");
    rd_at(1, 32'h00, 8, 8, 32'h55, "oor_no_alias_00");

    // 10-bit address / 16-bit data: 12-bit address frames, 18-bit data frames.
    wr_at(2, 32'h3A5, 32'hBEEF, 10, 16);
    wr_at(2, 32'h001, 32'h1234, 10, 16);
    rd_at(2, 32'h3A5, 10, 16, 32'hBEEF, "wide_read_3a5");
    rd_at(2, 32'h001, 10, 16, 32'h1234, "wide_read_001");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_ram_slave_param.md
SPI_RAM_SLAVE_PARAM -- requirements
Module: spi_ram_slave_param

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, RAM address width and address-payload length in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM word width and data-payload length in bits.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, number of RAM words (1 to 2^ADDR_WIDTH).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port SS_n  input  1  active-low slave select.
REQ-007 SHALL have port MOSI  input  1  serial data in, MSB first.
REQ-008 SHALL have port MISO  output  1  serial data out, registered, MSB first.

Function
REQ-009 SHALL implement states IDLE, RX, MEM, TX, DONE.
REQ-010 SHALL sample SS_n and MOSI on each rising clk; SS_n sampled high in any state -> IDLE next cycle, partial frame discarded, no RAM or pointer update.
REQ-011 SHALL, in IDLE with SS_n low, capture MOSI as frame bit 0 and enter RX.
REQ-012 SHALL shift one MOSI bit per cycle in RX; frame = 2-bit command then payload, N = ADDR_WIDTH for commands 00/10, DATA_WIDTH for 01/11.
REQ-013 SHALL enter MEM on the cycle after the (2+N)th bit is captured; MEM lasts exactly one cycle.
REQ-014 SHALL in MEM execute: 00 -> wr_ptr <= payload; 01 -> RAM[wr_ptr] <= payload; 10 -> rd_ptr <= payload; 11 -> tx_reg <= RAM[rd_ptr] (payload ignored).
REQ-015 SHALL go MEM -> TX for command 11, otherwise MEM -> DONE.
REQ-016 SHALL in TX drive MISO with tx_reg bits DATA_WIDTH-1 down to 0, one per cycle, first bit registered on the rising edge ending MEM, then enter DONE.
REQ-017 SHALL hold MISO at 0 in every state except TX.
REQ-018 SHALL ignore MOSI in TX and DONE; DONE exits only via SS_n high.
REQ-019 SHALL treat pointer values >= MEM_DEPTH as out of range: writes dropped, reads load tx_reg with 0.
REQ-020 SHALL support back-to-back frames separated by a single SS_n-high cycle.

Reset
REQ-021 SHALL on rst_n low force state IDLE, MISO 0, wr_ptr 0, rd_ptr 0, tx_reg 0, bit counter 0 immediately, independent of clk.
REQ-022 SHALL NOT clear RAM contents on reset.
REQ-023 SHALL abort any frame in progress when reset asserts mid-frame, with no RAM write.

Configuration
REQ-024 SHALL compile auto-increment when macro SPI_RAM_AUTO_INC_EN is defined: after command 01 wr_ptr <= wr_ptr+1, after command 11 rd_ptr <= rd_ptr+1, in the MEM cycle, wrapping MEM_DEPTH-1 -> 0.
REQ-025 SHALL hold wr_ptr and rd_ptr unchanged except by commands 00/10 when SPI_RAM_AUTO_INC_EN is not defined.

Verification (defaults 8/8/256)
REQ-026 Frames 00_00001111, 01_00001110, 10_00001111, 11_00000000 -> RAM[0x0F]=0x0E; MISO 0,0,0,0,1,1,1,0 on 8 consecutive cycles, first on the edge after MEM; MISO 0 before and after.
REQ-027 Write-data frame with SS_n raised after 5 payload bits -> RAM unchanged, state IDLE next cycle, MISO 0.
REQ-028 With SPI_RAM_AUTO_INC_EN: wr_ptr=0xFF, write 0xA5 then 0x5A -> RAM[0xFF]=0xA5, RAM[0x00]=0x5A; without macro -> RAM[0xFF]=0x5A.
REQ-029 rst_n pulsed low mid-TX -> MISO 0 immediately (no clk edge), pointers 0, RAM preserved.
REQ-030 MEM_DEPTH=200: write 0x33 at address 0xC8 -> no RAM change; read address 0xC8 -> MISO eight 0s.
REQ-031 ADDR_WIDTH=10, DATA_WIDTH=16: 12-bit address frame, 18-bit data frame, read returns 16 bits on MISO matching the written word.
